// File: rtl/pipe_stage_skid_reg_pkg.sv
// Shared definitions for the elastic pipeline register: occupancy encoding,
// NOP pattern, default widths and field indices.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } occ_state_t;

    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
    localparam int unsigned DEF_FIELD_W = 32;

    localparam int unsigned F_PC  = 0;
    localparam int unsigned F_PC8 = 1;
    localparam int unsigned F_IR  = 2;
    localparam int unsigned F_RD2 = 3;
    localparam int unsigned F_ALU = 4;

endpackage

// File: rtl/pipe_stage_skid_reg_if.sv
// Valid/ready bus for one pipeline stage: upstream offer side and downstream head side.
interface pipe_stage_skid_reg_if
    import pipe_pkg::*;
#(
    parameter int unsigned FIELD_W    = DEF_FIELD_W,
    parameter int unsigned NUM_FIELDS = 5,
    parameter int unsigned FLAG_W     = 1
);
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_FIELDS*FIELD_W-1:0] in_fields;
    logic [FLAG_W-1:0]             in_flags;
    logic                          out_valid;
    logic                          out_ready;
    logic [NUM_FIELDS*FIELD_W-1:0] out_fields;
    logic [FLAG_W-1:0]             out_flags;

    modport master (
        output in_valid, in_fields, in_flags, out_ready,
        input  in_ready, out_valid, out_fields, out_flags
    );

    modport slave (
        input  in_valid, in_fields, in_flags, out_ready,
        output in_ready, out_valid, out_fields, out_flags
    );

endinterface

// File: rtl/pipe_stage_skid_reg_entry.sv
// One pipeline entry: packed fields plus flags, with clear (to the NOP pattern)
// taking priority over load.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       FIELD_W    = DEF_FIELD_W,
    parameter int unsigned       NUM_FIELDS = 5,
    parameter int unsigned       FLAG_W     = 1,
    parameter logic [FIELD_W-1:0] RESET_VAL = FIELD_W'(NOP_WORD)
) (
    input  logic                          clk,
    input  logic                          load,
    input  logic                          clear,
    input  logic [NUM_FIELDS*FIELD_W-1:0] d_fields,
    input  logic [FLAG_W-1:0]             d_flags,
    output logic [NUM_FIELDS*FIELD_W-1:0] q_fields,
    output logic [FLAG_W-1:0]             q_flags
);

    always_ff @(posedge clk) begin
        if (clear) begin
            q_fields <= {NUM_FIELDS{RESET_VAL}};
            q_flags  <= '0;
        end else if (load) begin
            q_fields <= d_fields;
            q_flags  <= d_flags;
        end
    end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Elastic MEM-stage register: 2-entry skid buffer with registered in_ready,
// flush to bubble, and NOP pattern on the outputs whenever empty.
module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned        FIELD_W    = DEF_FIELD_W,
    parameter int unsigned        NUM_FIELDS = 5,
    parameter int unsigned        FLAG_W     = 1,
    parameter logic [FIELD_W-1:0] RESET_VAL  = FIELD_W'(NOP_WORD)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    pipe_stage_skid_reg_if.slave bus,
    output logic [1:0]           occupancy
);

    occ_state_t state;
    logic       in_fire;
    logic       out_fire;
    logic       kill;

    logic       main_load, main_clear, main_from_skid;
    logic       skid_load, skid_clear;

    logic [NUM_FIELDS*FIELD_W-1:0] main_d_fields, skid_q_fields;
    logic [FLAG_W-1:0]             main_d_flags, skid_q_flags;

    assign kill      = reset | flush;
    assign in_fire   = bus.in_valid & bus.in_ready;
    assign out_fire  = bus.out_valid & bus.out_ready;
    assign occupancy = state;

    always_ff @(posedge clk) begin
        if (kill) begin
            state         <= ST_EMPTY;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state         <= ST_ONE;
                        bus.out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && !out_fire) begin
                        state        <= ST_TWO;
                        bus.in_ready <= 1'b0;
                    end else if (!in_fire && out_fire) begin
                        state         <= ST_EMPTY;
                        bus.out_valid <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state        <= ST_ONE;
                        bus.in_ready <= 1'b1;
                    end
                end
                default: begin
                    state         <= ST_EMPTY;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Entry write enables mirror the state transitions above; the main entry is
    // cleared when it drains so the outputs show the NOP pattern without a mux.
    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (kill) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: main_load = in_fire;
                ST_ONE: begin
                    if (in_fire && out_fire)  main_load  = 1'b1;
                    else if (in_fire)         skid_load  = 1'b1;
                    else if (out_fire)        main_clear = 1'b1;
                end
                ST_TWO: begin
                    if (out_fire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        main_d_fields = bus.in_fields;
        main_d_flags  = bus.in_flags;
        if (main_from_skid) begin
            main_d_fields = skid_q_fields;
            main_d_flags  = skid_q_flags;
        end
    end

    pipe_entry_reg #(
        .FIELD_W    (FIELD_W),
        .NUM_FIELDS (NUM_FIELDS),
        .FLAG_W     (FLAG_W),
        .RESET_VAL  (RESET_VAL)
    ) u_main (
        .clk      (clk),
        .load     (main_load),
        .clear    (main_clear),
        .d_fields (main_d_fields),
        .d_flags  (main_d_flags),
        .q_fields (bus.out_fields),
        .q_flags  (bus.out_flags)
    );

    pipe_entry_reg #(
        .FIELD_W    (FIELD_W),
        .NUM_FIELDS (NUM_FIELDS),
        .FLAG_W     (FLAG_W),
        .RESET_VAL  (RESET_VAL)
    ) u_skid (
        .clk      (clk),
        .load     (skid_load),
        .clear    (skid_clear),
        .d_fields (bus.in_fields),
        .d_flags  (bus.in_flags),
        .q_fields (skid_q_fields),
        .q_flags  (skid_q_flags)
    );

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed self-checking bench for pipe_stage_skid_reg with default parameters.
module tb_pipe_stage_skid_reg;
    import pipe_pkg::*;

    localparam int unsigned FW = 32;
    localparam int unsigned NF = 5;
    localparam int unsigned FL = 1;
    localparam int unsigned DW = NF * FW;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [1:0] occupancy;

    int checks   = 0;
    int failures = 0;

    pipe_stage_skid_reg_if #(.FIELD_W(FW), .NUM_FIELDS(NF), .FLAG_W(FL)) bus ();

    pipe_stage_skid_reg #(
        .FIELD_W    (FW),
        .NUM_FIELDS (NF),
        .FLAG_W     (FL),
        .RESET_VAL  (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .bus       (bus),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Distinct, IR-derived contents in every field so whole-word compares catch field swaps.
    function automatic logic [DW-1:0] mk(input logic [31:0] ir);
        logic [31:0] pc;
        pc = ir << 4;
        return {ir ^ 32'hA100_0000, ir + 32'h10, ir, pc + 32'd8, pc};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] ir, input logic flag);
        bus.in_valid  = 1'b1;
        bus.in_fields = mk(ir);
        bus.in_flags  = flag;
    endtask

    task automatic check_state(input string tag, input int occ, input logic rdy, input logic vld);
        check({tag, "_occ"},   DW'(occupancy),     DW'(occ));
        check({tag, "_ready"}, DW'(bus.in_ready),  DW'(rdy));
        check({tag, "_valid"}, DW'(bus.out_valid), DW'(vld));
    endtask

    task automatic check_empty_out(input string tag);
        check({tag, "_fields"}, bus.out_fields, '0);
        check({tag, "_flags"},  DW'(bus.out_flags), '0);
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_fields = mk(32'h55);
        bus.in_flags  = 1'b1;
        bus.out_ready = 1'b0;

        // Reset held two cycles with a beat offered
        step();
        step();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        check_state("rst", 0, 1'b1, 1'b0);
        check_empty_out("rst");
        step();
        check_state("rst_post", 0, 1'b1, 1'b0);

        // Streaming at full rate
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push(32'h1000 + 32'(i), 1'b0);
            step();
            check($sformatf("stream_%0d", i), bus.out_fields, mk(32'h1000 + 32'(i)));
            check_state($sformatf("stream_%0d", i), 1, 1'b1, 1'b1);
        end
        bus.in_valid = 1'b0;
        step();
        check_state("stream_drain", 0, 1'b1, 1'b0);
        check_empty_out("stream_drain");

        // Backpressure fills the skid
        bus.out_ready = 1'b0;
        push(32'hA, 1'b0);
        step();
        check_state("bp_a", 1, 1'b1, 1'b1);
        check("bp_a_head", bus.out_fields, mk(32'hA));
        push(32'hB, 1'b1);
        step();
        check_state("bp_full", 2, 1'b0, 1'b1);
        check("bp_full_head", bus.out_fields, mk(32'hA));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check_state("bp_pop1", 1, 1'b1, 1'b1);
        check("bp_pop1_head", bus.out_fields, mk(32'hB));
        check("bp_pop1_flag", DW'(bus.out_flags), DW'(1'b1));
        step();
        check_state("bp_pop2", 0, 1'b1, 1'b0);
        check_empty_out("bp_pop2");

        // Flush with both entries full, beat offered in the flush cycle
        bus.out_ready = 1'b0;
        push(32'hD, 1'b1);
        step();
        push(32'hE, 1'b1);
        step();
        check_state("fl_full", 2, 1'b0, 1'b1);
        push(32'hC, 1'b1);
        flush = 1'b1;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check_state("fl_full_after", 0, 1'b1, 1'b0);
        check_empty_out("fl_full_after");

        // Flush in ONE while a beat actually fires: that beat is dropped
        push(32'hF, 1'b0);
        step();
        push(32'hC, 1'b1);
        flush = 1'b1;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check_state("fl_one", 0, 1'b1, 1'b0);
        step();
        check_state("fl_one_idle", 0, 1'b1, 1'b0);
        check_empty_out("fl_one_idle");

        // Simultaneous push and pop in ONE
        push(32'h1, 1'b0);
        step();
        check("sim_head1", bus.out_fields, mk(32'h1));
        push(32'h2, 1'b0);
        bus.out_ready = 1'b1;
        step();
        check("sim_head2", bus.out_fields, mk(32'h2));
        check_state("sim", 1, 1'b1, 1'b1);
        bus.in_valid = 1'b0;
        step();
        check_state("sim_drain", 0, 1'b1, 1'b0);

        // Stability under backpressure with changing inputs
        bus.out_ready = 1'b0;
        push(32'h77, 1'b1);
        step();
        push(32'h88, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            bus.in_fields = mk(32'h900 + 32'(i));
            bus.in_flags  = 1'(i);
            bus.in_valid  = (i % 2) == 0;
            check($sformatf("hold_%0d", i), bus.out_fields, mk(32'h77));
            check($sformatf("hold_flag_%0d", i), DW'(bus.out_flags), DW'(1'b1));
            check($sformatf("hold_occ_%0d", i), DW'(occupancy), DW'(2));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("hold_pop_head", bus.out_fields, mk(32'h88));
        check("hold_pop_flag", DW'(bus.out_flags), '0);
        step();
        check_state("hold_drain", 0, 1'b1, 1'b0);

        // Reset dominates flush mid-transfer
        bus.out_ready = 1'b0;
        push(32'h33, 1'b1);
        step();
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        flush        = 1'b1;
        step();
        reset = 1'b0;
        flush = 1'b0;
        check_state("rst_mid", 0, 1'b1, 1'b0);
        check_empty_out("rst_mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
